fp_div_seq: RTL
===============

// Module: fp_div_seq
// PURPOSE
//  Iterative FP16 divider, y = a / b: the inverse operation of fp_mul. Radix-2 restoring mantissa
//  division, one quotient bit per cycle, with valid/ready handshakes on both sides.
//  Used for normalisation/scaling of MAC-row outputs. One division is in flight at a time.
// PARAMETERS
//  QBITS         14  quotient bits produced (1 int + 11 sig + guard + round); fixed, not overridable
//  FLUSH_DENORM  0   1: subnormal inputs read as signed zero; subnormal results flushed to signed zero
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   a/b valid
//  in_ready   out  1   high only in IDLE and while rst is low
//  a          in   16  dividend, `FP16_WIDTH
//  b          in   16  divisor, `FP16_WIDTH
//  out_valid  out  1   y/flags valid; held until out_ready
//  out_ready  in   1   consumer accepts the result
//  y          out  16  quotient
//  flags      out  4   {invalid, div_by_zero, overflow, underflow}; sticky per result only
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, y=16'h0000, flags=0, in_ready=0 while rst is high.
//   rst asserted mid-operation aborts the operation; no partial result is ever presented.
//  FSM: IDLE -> UNPACK -> DIV (QBITS cycles, counter 0..QBITS-1) -> ROUND -> DONE -> IDLE.
//   IDLE: accept when in_valid&&in_ready; latch a, b.
//   UNPACK: classify operands, normalise subnormals (LZC), compute sign = sa^sb and
//    e = ea - eb + 15 (signed 8-bit). A special result goes directly to DONE.
//   DIV: rem = ma (11b, hidden 1). Each cycle: if rem >= mb then q_bit = 1, rem -= mb; then rem <<= 1.
//   ROUND: if q[13]==0 then shift left 1 and e -= 1. Take 11 sig bits plus guard and round;
//    sticky = |rem. Apply round-to-nearest-even. A mantissa carry-out increments e.
//    e >= 31: signed Inf, overflow=1.
//    e <= 0: right-shift by 1-e into sticky (shift > 13 yields 0), exp field = 0;
//     underflow=1 if the result is inexact.
//   DONE: out_valid=1; y and flags stable until out_ready. On the handshake, go to IDLE and clear out_valid.
//  Latency: normal operands give out_valid 17 edges after the accept edge (inclusive).
//   Specials give out_valid 2 edges after. Throughput is one result per 18 cycles minimum.
//  Specials, first match wins:
//   NaN in, 0/0, Inf/Inf: y = 7E00, invalid=1.
//   Inf/x: signed Inf. x/Inf: signed 0. 0/x: signed 0.
//   finite nonzero / 0: signed Inf, div_by_zero=1.
//  in_ready stays 0 in every state except IDLE. in_valid outside IDLE is ignored, never queued.
//  Inputs are sampled only at the accept edge; later changes to a/b have no effect.
// STRUCTURE
//  fp16_defs.vh: add FP16_QNAN (16'h7E00), FP16_EXP_BIAS (15), FP16_MAN_W (10), FP16_EXP_W (5),
//   FP16_FLAG_* bit indices, and the FSM state encodings.
//  Sub-module fp16_unpack (combinational): classify zero/sub/norm/inf/nan, lzc-normalise,
//   output {sign, signed exp, 11b mant}. Shared with future fp_mul rework.
//  Top level holds the FSM, iteration counter, remainder/quotient regs and the round/pack stage.
// TESTING
//  3E00 (1.5) reference: 4200 (3.0)/3E00 -> y=4000, flags=0, out_valid on edge 17.
//  3C00/4200 -> y=3555 (round-down case); 3C00/0000 -> y=7C00, flags=0100, latency 2.
//  0000/0000 -> 7E00, flags=1000; FC00/3800 -> FC00; 7BFF/3800 -> 7C00, flags=0010.
//  0003/4000 -> 0002 (tie to even), flags=0001. 0001/4000 -> 0000, flags=0001.
//   With FLUSH_DENORM=1: 0003/3C00 -> 0000.
//  Backpressure: out_ready=0 for 10 cycles -> y and flags stable, in_ready=0,
//   a second in_valid not accepted; after release the next op is accepted.
//  Reset pulse at DIV iteration 5 -> out_valid=0, y=0; a new op afterwards completes correctly.
//   Also run 10k random normal/subnormal pairs against a $realtobits-based model (bit-exact).

Source files
------------

// File: rtl/fp_div_seq_pkg.sv
// fp_div_seq_pkg: FP16 constants, flag bit positions and divider FSM states
package fp_div_seq_pkg;

    localparam int QBITS         = 14;
    localparam int FP16_EXP_BIAS = 15;
    localparam int FP16_MAN_W    = 10;
    localparam int FP16_EXP_W    = 5;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    localparam int FP16_FLAG_INVALID = 3;
    localparam int FP16_FLAG_DBZ     = 2;
    localparam int FP16_FLAG_OVF     = 1;
    localparam int FP16_FLAG_UNF     = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_t;

    function automatic logic [15:0] fp16_inf(input logic s);
        return {s, 5'h1F, 10'd0};
    endfunction

endpackage

// File: rtl/fp_div_seq_unpack.sv
// fp_div_seq_unpack: classify an FP16 operand and normalise subnormals to {sign, signed exp, 11b mant}
module fp_div_seq_unpack
    import fp_div_seq_pkg::*;
#(
    parameter int FLUSH_DENORM = 0
) (
    input  logic              [15:0] x,
    output logic                     sign,
    output logic signed       [7:0]  expo,
    output logic              [10:0] mant,
    output logic                     is_zero,
    output logic                     is_inf,
    output logic                     is_nan
);

    logic [FP16_EXP_W-1:0] ef;
    logic [FP16_MAN_W-1:0] fr;
    logic [3:0]            lz;
    logic [10:0]           sub_m;
    logic                  sub;

    assign ef = x[FP16_MAN_W+FP16_EXP_W-1:FP16_MAN_W];
    assign fr = x[FP16_MAN_W-1:0];

    // leading-zero count of the fraction, then shift the first set bit into the hidden position
    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < FP16_MAN_W; i++)
            if (fr[i]) lz = 4'(FP16_MAN_W - 1 - i);
        sub     = (ef == '0) && (fr != '0);
        sub_m   = {1'b0, fr} << (lz + 4'd1);
        sign    = x[15];
        is_nan  = (&ef) && (fr != '0);
        is_inf  = (&ef) && (fr == '0);
        is_zero = ((ef == '0) && (fr == '0)) || ((FLUSH_DENORM != 0) && sub);
        mant    = sub ? sub_m : {1'b1, fr};
        expo    = sub ? 8'd0 - {4'd0, lz} : {3'd0, ef};
    end

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative FP16 divider, radix-2 restoring, one quotient bit per cycle
module fp_div_seq
    import fp_div_seq_pkg::*;
#(
    parameter int FLUSH_DENORM = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y,
    output logic [3:0]  flags
);

    state_t state_q, state_d;
    logic [15:0]       a_q, a_d, b_q, b_d, y_q, y_d;
    logic [3:0]        flags_q, flags_d, cnt_q, cnt_d;
    logic [11:0]       rem_q, rem_d, rem_sub;
    logic [QBITS-1:0]  q_q, q_d;
    logic [10:0]       mb_q, mb_d;
    logic signed [7:0] e_q, e_d;
    logic              sign_q, sign_d;

    logic              ua_s, ub_s, ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;
    logic signed [7:0] ua_e, ub_e;
    logic [10:0]       ua_m, ub_m;

    logic              spec_hit, spec_s;
    logic [15:0]       spec_y;
    logic [3:0]        spec_f;

    logic              norm, big, tiny, wide, st0, dst, g, sb, inc;
    logic signed [7:0] e1;
    logic [7:0]        sh;
    logic [12:0]       sig, mask, dsig;
    logic [4:0]        expf_m1;
    logic [14:0]       packed_v;
    logic [15:0]       rnd_y;
    logic [3:0]        rnd_f;

    fp_div_seq_unpack #(.FLUSH_DENORM(FLUSH_DENORM)) u_unpack_a (
        .x(a_q), .sign(ua_s), .expo(ua_e), .mant(ua_m),
        .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan)
    );

    fp_div_seq_unpack #(.FLUSH_DENORM(FLUSH_DENORM)) u_unpack_b (
        .x(b_q), .sign(ub_s), .expo(ub_e), .mant(ub_m),
        .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan)
    );

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign y         = y_q;
    assign flags     = flags_q;

    // special-operand result, first matching rule wins
    always_comb begin
        spec_s   = ua_s ^ ub_s;
        spec_hit = 1'b1;
        spec_y   = FP16_QNAN;
        spec_f   = 4'd0;
        if (ua_nan || ub_nan || (ua_zero && ub_zero) || (ua_inf && ub_inf))
            spec_f[FP16_FLAG_INVALID] = 1'b1;
        else if (ua_inf)
            spec_y = fp16_inf(spec_s);
        else if (ub_inf || ua_zero)
            spec_y = {spec_s, 15'd0};
        else if (ub_zero) begin
            spec_y = fp16_inf(spec_s);
            spec_f[FP16_FLAG_DBZ] = 1'b1;
        end else
            spec_hit = 1'b0;
    end

    // normalise the quotient, denormalise tiny results, round to nearest even and pack
    always_comb begin
        norm     = q_q[QBITS-1];
        e1       = norm ? e_q : e_q - 8'sd1;
        sig      = norm ? q_q[13:1] : q_q[12:0];
        st0      = (norm & q_q[0]) | (|rem_q);
        big      = e1 >= 8'sd31;
        tiny     = e1 <= 8'sd0;
        sh       = 8'(8'sd1 - e1);
        wide     = sh > 8'(QBITS - 1);
        mask     = (13'd1 << sh[3:0]) - 13'd1;
        dsig     = !tiny ? sig : wide ? 13'd0 : sig >> sh[3:0];
        dst      = st0 | (tiny & (wide | (|(sig & mask))));
        g        = dsig[1];
        sb       = dsig[0] | dst;
        inc      = g & (sb | dsig[2]);
        expf_m1  = tiny ? 5'd0 : e1[4:0] - 5'd1;
        packed_v = {expf_m1, 10'd0} + {4'd0, dsig[12:2]} + 15'(inc);
        rnd_y    = big ? fp16_inf(sign_q)
                 : (tiny && FLUSH_DENORM != 0) ? {sign_q, 15'd0}
                 : {sign_q, packed_v};
        rnd_f    = 4'd0;
        rnd_f[FP16_FLAG_OVF] = big | (packed_v == 15'h7C00);
        rnd_f[FP16_FLAG_UNF] = tiny & (g | sb | (FLUSH_DENORM != 0));
    end

    // FSM next state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        mb_d    = mb_q;
        e_d     = e_q;
        sign_d  = sign_q;
        rem_sub = rem_q - {1'b0, mb_q};
        case (state_q)
            S_IDLE: if (in_valid && in_ready) begin
                a_d     = a;
                b_d     = b;
                state_d = S_UNPACK;
            end
            S_UNPACK: begin
                sign_d  = spec_s;
                e_d     = ua_e - ub_e + 8'(FP16_EXP_BIAS);
                rem_d   = {1'b0, ua_m};
                mb_d    = ub_m;
                q_d     = '0;
                cnt_d   = 4'd0;
                y_d     = spec_hit ? spec_y : y_q;
                flags_d = spec_hit ? spec_f : flags_q;
                state_d = spec_hit ? S_DONE : S_DIV;
            end
            S_DIV: begin
                rem_d   = ((rem_q >= {1'b0, mb_q}) ? rem_sub : rem_q) << 1;
                q_d     = {q_q[QBITS-2:0], rem_q >= {1'b0, mb_q}};
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'(QBITS - 1)) ? S_ROUND : S_DIV;
            end
            S_ROUND: begin
                y_d     = rnd_y;
                flags_d = rnd_f;
                state_d = S_DONE;
            end
            S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any division in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            mb_q    <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            mb_q    <= mb_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
        end
    end

endmodule
